// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide, one shift-add or restoring-subtract step per cycle.
// Operands are converted to magnitudes on entry and the sign is fixed in DONE.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t            state_q;
    logic [4:0]        cnt_q;
    logic [2:0]        fn_q;
    logic [XLEN-1:0]   b_q, result_q, res_d, quo, rem, m1, m2;
    logic [2*XLEN-1:0] acc_q, acc_d, prod;
    logic [XLEN:0]     sum, diff;
    logic              neg_q, negr_q, busy_q, valid_q, s1, s2, dz, ovf;
    always_comb begin
        s1   = rs1[XLEN-1] & ~(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
        s2   = rs2[XLEN-1] & (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
        m1   = s1 ? -rs1 : rs1;
        m2   = s2 ? -rs2 : rs2;
        dz   = funct3[2] && rs2 == '0;
        ovf  = (funct3 == 3'b100 || funct3 == 3'b110) && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
        // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        acc_d = !fn_q[2] ? {sum, acc_q[XLEN-1:1]}
              : diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        res_d = fn_q[2] ? (fn_q[1] ? rem : quo) : (fn_q == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fn_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        fn_q  <= funct3;
                        cnt_q <= '0;
                        b_q   <= m2;
                        // special cases preload acc so the DONE sign fix yields the fixed answer
                        if (dz || ovf) begin
                            state_q <= DONE;
                            acc_q   <= {ovf ? '0 : rs1, ovf ? {1'b1, {(XLEN-1){1'b0}}} : {XLEN{1'b1}}};
                            neg_q   <= 1'b0;
                            negr_q  <= 1'b0;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            acc_q   <= {{XLEN{1'b0}}, m1};
                            neg_q   <= s1 ^ s2;
                            negr_q  <= s1;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    valid_q  <= 1'b1;
                    result_q <= res_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: latency/arithmetic reference model with per-cycle compare, directed vectors and random traffic.
module tb_muldiv_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        busy, valid;
    logic [31:0] result;
    int n_chk = 0, n_fail = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .valid(valid), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && b == 0) || ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0] pu;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        pu = {32'b0, a} * {32'b0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    // model: cycles left until the result appears; busy while more than one cycle remains on a normal op
    int          m_left;
    logic        m_spec, m_valid;
    logic [31:0] m_pend, m_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_spec <= 1'b0; m_valid <= 1'b0; m_pend <= '0; m_res <= '0;
        end else if (flush) begin
            m_left <= 0; m_valid <= 1'b0;
        end else if (m_left == 0) begin
            m_valid <= 1'b0;
            if (start) begin
                m_spec <= is_special(funct3, rs1, rs2);
                m_left <= is_special(funct3, rs1, rs2) ? 1 : 33;
                m_pend <= ref_res(funct3, rs1, rs2);
            end
        end else begin
            m_left <= m_left - 1;
            m_valid <= (m_left == 1);
            if (m_left == 1) m_res <= m_pend;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", {31'b0, busy}, {31'b0, !m_spec && m_left > 1});
            chk("valid", {31'b0, valid}, {31'b0, m_valid});
            chk("result", result, m_res);
        end
    end

    task automatic sync();
        @(negedge clk); #1;
    endtask

    // caller is at negedge+1; checks the literal answer and the cycle in which valid appears
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int cyc = 0;
        funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin #1; start = 1'b0; end
            if (valid) break;
        end
        chk("dir_lat", cyc, lat);
        chk("dir_res", result, exp);
    endtask

    logic [2:0]  d_f[14]   = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd6, 3'd7, 3'd0, 3'd5, 3'd5};
    logic [31:0] d_a[14]   = '{7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               5, 5, 32'h80000000, 32'h80000000, 100, 0, 100, 100};
    logic [31:0] d_b[14]   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 2, 2,
                               0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 9, 0, 7};
    logic [31:0] d_e[14]   = '{32'hFFFFFFEB, 32'hFFFFFFFE, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 5, 32'h80000000, 0, 2, 0, 32'hFFFFFFFF, 14};
    int          d_l[14]   = '{34, 34, 34, 34, 34, 34, 2, 2, 2, 2, 34, 34, 2, 34};

    initial begin
        int cyc;
        #2;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_result", result, 0);
        sync();
        sync();
        rst = 1'b0;
        sync();
        for (int i = 0; i < 14; i++) begin
            do_op(d_f[i], d_a[i], d_b[i], d_e[i], d_l[i]);
            sync();
        end
        // flush on 10th CALC cycle with start held throughout
        funct3 = 3'd0; rs1 = 5; rs2 = 6; start = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 11) begin
                chk("flush_busy", {31'b0, busy}, 0);
                chk("flush_result", result, 14);
            end
            if (cyc > 11 && valid) break;
            #1;
            if (cyc == 1) begin rs1 = 3; rs2 = 4; end
            flush = (cyc == 10);
            if (cyc == 12) start = 1'b0;
        end
        chk("flush_lat", cyc, 45);
        chk("flush_res", result, 12);
        sync();
        // async reset between edges during CALC
        funct3 = 3'd4; rs1 = 1000; rs2 = 7; start = 1'b1;
        sync();
        start = 1'b0;
        repeat (5) sync();
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_valid", {31'b0, valid}, 0);
        chk("arst_result", result, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        do_op(3'd4, 9, 3, 3, 34);
        sync();
        // random traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 59) == 0);
            funct3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rs1 = 32'h80000000;
                1: rs1 = $urandom_range(0, 20);
                default: rs1 = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rs2 = 0;
                1: rs2 = 32'hFFFFFFFF;
                2: rs2 = $urandom_range(1, 20);
                default: rs2 = $urandom;
            endcase
            sync();
        end
        start = 1'b0; flush = 1'b0;
        repeat (40) sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
